rst_seq: RTL and testbench

- Multi-domain reset sequencer that runs on the generated system clock, downstream of the clock generator.
- Merges the power-on/lock reset, several debounced asynchronous reset request pins and a software reset pulse.
- Holds every reset domain asserted for a minimum time, then releases the domains one at a time in index order with a fixed gap between releases.
- Records a sticky cause for the most recent resets.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_debounce.sv | 59 +++++
 rtl/rst_seq.sv | 143 ++++++++++++++
 tb/tb_rst_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer slice.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_POR_c      = 0;
  localparam int CAUSE_SW_c       = 1;
  localparam int CAUSE_SRC_BASE_c = 2;

  // Bits needed to hold a counter whose terminal value is term.
  function automatic int cnt_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Purpose: synchronize one async active-low request pin and debounce its level.
// Latency: SYNC_STAGES_p + DEBOUNCE_CNT_p cycles from pin edge to level flip.
// Backpressure: none; level output plus a one-cycle falling-edge pulse.
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES_p  = 3,
  parameter int DEBOUNCE_CNT_p = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin_n,
  output logic o_lvl,
  output logic o_fall
);

  localparam int DB_W = cnt_width(DEBOUNCE_CNT_p);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT_p - 1);

  logic [SYNC_STAGES_p-1:0] sync_q;
  logic [DB_W-1:0]          cnt_q;
  logic                     lvl_q;
  logic                     fall_q;
  logic                     synced;

  assign synced = sync_q[SYNC_STAGES_p-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES_p-2:0], i_pin_n};
    end
  end

  // Any cycle agreeing with the current level restarts the stability count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (synced == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q  <= '0;
        lvl_q  <= synced;
        fall_q <= ~synced;
      end else begin
        cnt_q <= cnt_q + DB_W'(1);
      end
    end
  end

  assign o_lvl  = lvl_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/rst_seq.sv
// Purpose: merge reset requests, hold all domains, then release them in index order.
// Latency: request to all-asserted in one edge; release HOLD_CNT_p then STAGE_DLY_p per domain.
// Backpressure: none; registered level outputs only.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_SRC_p      = 2,
  parameter int NUM_DOM_p      = 3,
  parameter int SYNC_STAGES_p  = 3,
  parameter int DEBOUNCE_CNT_p = 100000,
  parameter int HOLD_CNT_p     = 1000,
  parameter int STAGE_DLY_p    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_SRC_p-1:0]   i_src_rst_n,
  input  logic                   i_sw_rst_req,
  input  logic                   i_cause_clr,
  output logic [NUM_DOM_p-1:0]   o_rst_n,
  output logic                   o_busy,
  output logic [NUM_SRC_p+1:0]   o_cause
);

  localparam int HOLD_W = cnt_width(HOLD_CNT_p);
  localparam int STG_W  = cnt_width(STAGE_DLY_p);
  localparam int DOM_W  = cnt_width(NUM_DOM_p);

  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CNT_p - 1);
  localparam logic [STG_W-1:0]     STG_LAST  = STG_W'(STAGE_DLY_p - 1);
  localparam logic [DOM_W-1:0]     DOM_LAST  = DOM_W'(NUM_DOM_p - 1);
  localparam logic [NUM_DOM_p-1:0] DOM_ONE   = NUM_DOM_p'(1);
  localparam logic [NUM_SRC_p+1:0] CAUSE_RST = (NUM_SRC_p + 2)'(1) << CAUSE_POR_c;

  logic [NUM_SRC_p-1:0] src_lvl;
  logic [NUM_SRC_p-1:0] src_fall;
  logic                 req_act;

  state_e               state_q;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic [STG_W-1:0]     stg_cnt_q;
  logic [DOM_W-1:0]     dom_idx_q;
  logic [NUM_DOM_p-1:0] rst_n_q;
  logic                 busy_q;
  logic [NUM_SRC_p+1:0] cause_q;
  logic [NUM_SRC_p+1:0] cause_nxt;

  for (genvar k = 0; k < NUM_SRC_p; k++) begin : g_src
    rst_debounce #(
      .SYNC_STAGES_p  (SYNC_STAGES_p),
      .DEBOUNCE_CNT_p (DEBOUNCE_CNT_p)
    ) u_debounce (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_pin_n (i_src_rst_n[k]),
      .o_lvl   (src_lvl[k]),
      .o_fall  (src_fall[k])
    );
  end

  assign req_act = (~&src_lvl) | i_sw_rst_req;

  // A request from any state collapses every domain at once and restarts the hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      dom_idx_q  <= '0;
      rst_n_q    <= '0;
      busy_q     <= 1'b1;
    end else if (req_act) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      dom_idx_q  <= '0;
      rst_n_q    <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            rst_n_q   <= DOM_ONE;
            stg_cnt_q <= '0;
            dom_idx_q <= DOM_W'(1);
            if (NUM_DOM_p == 1) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (stg_cnt_q == STG_LAST) begin
            stg_cnt_q <= '0;
            rst_n_q   <= rst_n_q | (DOM_ONE << dom_idx_q);
            dom_idx_q <= dom_idx_q + DOM_W'(1);
            if (dom_idx_q == DOM_LAST) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
            end
          end else begin
            stg_cnt_q <= stg_cnt_q + STG_W'(1);
          end
        end
        RUN: begin
          rst_n_q <= '1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= HOLD;
          hold_cnt_q <= '0;
          rst_n_q    <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  // Clear applies first so a same-cycle set survives for its bit.
  always_comb begin
    cause_nxt = i_cause_clr ? '0 : cause_q;
    if (i_sw_rst_req) cause_nxt[CAUSE_SW_c] = 1'b1;
    for (int k = 0; k < NUM_SRC_p; k++) begin
      if (src_fall[k]) cause_nxt[CAUSE_SRC_BASE_c + k] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cause_q <= CAUSE_RST;
    end else begin
      cause_q <= cause_nxt;
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_busy  = busy_q;
  assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Randomized and directed stimulus against a quiet-time reference model with a queued scoreboard.
module tb_rst_seq;

  localparam int NS = 2;
  localparam int ND = 3;
  localparam int SY = 2;
  localparam int DB = 4;
  localparam int HC = 5;
  localparam int SD = 3;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [NS-1:0]   i_src_rst_n = '1;
  logic            i_sw_rst_req = 1'b0;
  logic            i_cause_clr = 1'b0;
  logic [ND-1:0]   o_rst_n;
  logic            o_busy;
  logic [NS+1:0]   o_cause;

  rst_seq #(
    .NUM_SRC_p      (NS),
    .NUM_DOM_p      (ND),
    .SYNC_STAGES_p  (SY),
    .DEBOUNCE_CNT_p (DB),
    .HOLD_CNT_p     (HC),
    .STAGE_DLY_p    (SD)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_src_rst_n  (i_src_rst_n),
    .i_sw_rst_req (i_sw_rst_req),
    .i_cause_clr  (i_cause_clr),
    .o_rst_n      (o_rst_n),
    .o_busy       (o_busy),
    .o_cause      (o_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ND-1:0] rst_n;
    logic          busy;
    logic [NS+1:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en = 1'b0;

  // Reference model: debounced levels from a pin-history queue, domain state from
  // the number of consecutive request-free edges.
  logic [NS-1:0] pin_hist[$];
  logic [NS-1:0] m_lvl;
  logic [NS-1:0] m_fell;
  int            m_run[NS];
  int            quiet;
  logic [NS+1:0] m_cause;

  function automatic void model_reset();
    pin_hist.delete();
    for (int i = 0; i < SY; i++) pin_hist.push_back('1);
    m_lvl   = '1;
    m_fell  = '0;
    for (int k = 0; k < NS; k++) m_run[k] = 0;
    quiet   = 0;
    m_cause = (NS + 2)'(1);
  endfunction

  function automatic void model_edge();
    logic [NS-1:0] seen;
    logic          act;
    exp_t          e;
    act = i_sw_rst_req || (m_lvl != '1);
    if (i_cause_clr) m_cause = '0;
    if (i_sw_rst_req) m_cause[1] = 1'b1;
    for (int k = 0; k < NS; k++) if (m_fell[k]) m_cause[2 + k] = 1'b1;
    if (act) quiet = 0;
    else if (quiet < 100000) quiet = quiet + 1;
    seen = pin_hist.pop_front();
    pin_hist.push_back(i_src_rst_n);
    m_fell = '0;
    for (int k = 0; k < NS; k++) begin
      if (seen[k] == m_lvl[k]) m_run[k] = 0;
      else begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == DB) begin
          m_lvl[k]  = seen[k];
          m_fell[k] = !seen[k];
          m_run[k]  = 0;
        end
      end
    end
    for (int d = 0; d < ND; d++) e.rst_n[d] = (quiet >= HC + d * SD);
    e.busy  = (quiet < HC + (ND - 1) * SD);
    e.cause = m_cause;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  // Inputs given here are seen by the DUT from the following edge onward.
  task automatic step(input logic [NS-1:0] src, input logic sw, input logic clr);
    @(posedge i_clk);
    #1;
    if (sb_en) model_edge();
    i_src_rst_n  = src;
    i_sw_rst_req = sw;
    i_cause_clr  = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (sb_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({o_rst_n, o_busy, o_cause} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got rst_n=%b busy=%b cause=%b want rst_n=%b busy=%b cause=%b",
                   $time, o_rst_n, o_busy, o_cause, e.rst_n, e.busy, e.cause);
        end
      end
    end
  end

  initial begin : stim
    logic [NS-1:0] src;
    #12;
    check("reset_rst_n", 8'(o_rst_n), 8'd0);
    check("reset_busy", 8'(o_busy), 8'd1);
    check("reset_cause", 8'(o_cause), 8'b0001);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    sb_en = 1'b1;

    // Power-on release, then a short glitch and a real request on source 0.
    idle(15);
    for (int i = 0; i < 3; i++) step(2'b10, 1'b0, 1'b0);
    idle(12);
    for (int i = 0; i < 7; i++) step(2'b10, 1'b0, 1'b0);
    idle(25);

    // Clear colliding with a software request.
    step('1, 1'b1, 1'b1);
    idle(15);

    // Software request shortly after the first domain is released.
    step('1, 1'b1, 1'b0);
    idle(6);
    step('1, 1'b1, 1'b0);
    idle(16);

    // Long-held request on source 1.
    for (int i = 0; i < 50; i++) step(2'b01, 1'b0, 1'b0);
    idle(25);
    step('1, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a cycle while running.
    @(posedge i_clk);
    #3;
    sb_en = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_n", 8'(o_rst_n), 8'd0);
    check("async_busy", 8'(o_busy), 8'd1);
    check("async_cause", 8'(o_cause), 8'b0001);
    exp_q.delete();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    sb_en = 1'b1;
    idle(15);

    // Random requests, pulses and clears.
    src = '1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) src[$urandom_range(0, NS - 1)] ^= 1'b1;
      step(src, ($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0));
    end
    src = '1;
    idle(30);

    @(negedge i_clk);
    #1;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
